// File: rtl/minterm_pkg.sv
// minterm_pkg
//   Shared types and constants for minterm_match_detector.
//   - state_t           : qualification FSM states
//   - RST_VALUE_DEF     : reset match value, reproduces S = ~A & B & C (A = MSB)
//   - RST_MASK_DEF      : reset care mask, all three bits compared
//   - hold_in_range()   : elaboration-time legality check for HOLD vs RUN_W
package minterm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    HELD = 2'd2
  } state_t;

  localparam logic [2:0] RST_VALUE_DEF = 3'b011;
  localparam logic [2:0] RST_MASK_DEF  = 3'b111;

  // HOLD must be reachable by the run counter without wrapping.
  function automatic bit hold_in_range(input int unsigned hold, input int unsigned run_w);
    return (hold >= 1) && (longint'(hold) < (longint'(1) << run_w));
  endfunction

endpackage

// File: rtl/minterm_match_detector_sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones. Synchronous clear has priority
//   over increment.
// Ports
//   clk    in   1  rising-edge clock
//   rst    in   1  asynchronous active-high reset, clears count
//   clr    in   1  synchronous clear
//   inc    in   1  increment request (ignored while saturated)
//   count  out  W  current value
//   sat    out  1  count is all-ones
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  assign sat = &count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/minterm_match_detector.sv
// minterm_match_detector
//   Registered, parametrised successor to the 3-input minterm gate
//   (S = ~A & B & C). Compares each valid sample against a programmable
//   value/care-mask and emits a one-cycle detect once HOLD consecutive
//   valid samples have matched.
//
//   Optional feature macro: MINTERM_HIT_COUNTER_EN adds the saturating
//   hit_count output; without it the port and counter do not exist.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      din carries a sample this cycle
//   din        in   WIDTH  sample vector
//   cfg_load   in   1      load cfg_value/cfg_mask at this edge
//   cfg_value  in   WIDTH  new match value
//   cfg_mask   in   WIDTH  new care mask (1 = compared)
//   match_q    out  1      registered raw match of last valid sample
//   detect     out  1      one-cycle qualification pulse
//   active     out  1      qualified match currently held
//   hit_count  out  CNT_W  saturating detect count (macro only)
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no match run in progress, run = 0
// QUAL  | 1..HOLD-1 consecutive valid matches seen
// HELD  | HOLD reached; stays until the first valid mismatch
module minterm_match_detector
  import minterm_pkg::*;
#(
  parameter int unsigned      WIDTH     = 3,
  parameter int unsigned      HOLD      = 1,
  parameter int unsigned      RUN_W     = 4,
  parameter int unsigned      CNT_W     = 8,
  parameter logic [WIDTH-1:0] RST_VALUE = WIDTH'(RST_VALUE_DEF),
  parameter logic [WIDTH-1:0] RST_MASK  = WIDTH'(RST_MASK_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_value,
  input  logic [WIDTH-1:0] cfg_mask,
  output logic             match_q,
  output logic             detect,
  output logic             active
`ifdef MINTERM_HIT_COUNTER_EN
  ,
  output logic [CNT_W-1:0] hit_count
`endif
);

  if (!hold_in_range(HOLD, RUN_W)) begin : g_bad_hold
    $error("minterm_match_detector: HOLD=%0d not in 1..2**RUN_W-1 (RUN_W=%0d)", HOLD, RUN_W);
  end

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("minterm_match_detector: CNT_W must be at least 1");
  end

  localparam logic [RUN_W-1:0] HOLD_R = RUN_W'(HOLD);

  logic [WIDTH-1:0] value_r;
  logic [WIDTH-1:0] mask_r;
  state_t           state_q;
  logic [RUN_W-1:0] run;
  logic             run_sat;
  logic             match_c;
  logic             hold_reached;
  logic             run_inc;
  logic             run_clr;

  // Bits with mask 0 are forced to "equal", so mask_r == 0 matches everything.
  assign match_c = &(~(din ^ value_r) | ~mask_r);

  // run is 0 in IDLE, so the same compare covers both the HOLD == 1 case
  // from IDLE and the last step of QUAL.
  assign hold_reached = ((run + RUN_W'(1)) == HOLD_R);

  // Run stops counting once HELD; any valid mismatch or reconfiguration
  // restarts qualification from zero.
  assign run_inc = !cfg_load && in_valid && match_c && (state_q != HELD) && !run_sat;
  assign run_clr = cfg_load || (in_valid && !match_c);

  sat_counter #(
    .W (RUN_W)
  ) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (run_clr),
    .inc   (run_inc),
    .count (run),
    .sat   (run_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r <= RST_VALUE;
      mask_r  <= RST_MASK;
      state_q <= IDLE;
      match_q <= 1'b0;
      detect  <= 1'b0;
    end else if (cfg_load) begin
      // The sample presented alongside a reconfiguration is dropped.
      value_r <= cfg_value;
      mask_r  <= cfg_mask;
      state_q <= IDLE;
      match_q <= 1'b0;
      detect  <= 1'b0;
    end else begin
      detect <= 1'b0;
      if (in_valid) begin
        match_q <= match_c;
        case (state_q)
          IDLE, QUAL: begin
            if (!match_c) begin
              state_q <= IDLE;
            end else if (hold_reached) begin
              state_q <= HELD;
              detect  <= 1'b1;
            end else begin
              state_q <= QUAL;
            end
          end
          HELD: begin
            if (!match_c) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign active = (state_q == HELD);

`ifdef MINTERM_HIT_COUNTER_EN
  logic hit_sat;

  // Counts detect pulses; only rst clears it, reconfiguration does not.
  sat_counter #(
    .W (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (detect && !hit_sat),
    .count (hit_count),
    .sat   (hit_sat)
  );
`endif

endmodule

// File: tb/tb_minterm_match_detector.sv
// Directed bench for minterm_match_detector: u1 uses HOLD=1 (CNT_W=2),
// u3 uses HOLD=3. Both share clock, reset and stimulus.
module tb_minterm_match_detector;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] din;
  logic       cfg_load;
  logic [2:0] cfg_value;
  logic [2:0] cfg_mask;

  logic       match1, detect1, active1;
  logic       match3, detect3, active3;
`ifdef MINTERM_HIT_COUNTER_EN
  logic [1:0] hit1;
  logic [7:0] hit3;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  minterm_match_detector #(.HOLD(1), .CNT_W(2)) u1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .din       (din),
    .cfg_load  (cfg_load),
    .cfg_value (cfg_value),
    .cfg_mask  (cfg_mask),
    .match_q   (match1),
    .detect    (detect1),
    .active    (active1)
`ifdef MINTERM_HIT_COUNTER_EN
    ,
    .hit_count (hit1)
`endif
  );

  minterm_match_detector #(.HOLD(3)) u3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .din       (din),
    .cfg_load  (cfg_load),
    .cfg_value (cfg_value),
    .cfg_mask  (cfg_mask),
    .match_q   (match3),
    .detect    (detect3),
    .active    (active3)
`ifdef MINTERM_HIT_COUNTER_EN
    ,
    .hit_count (hit3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] d);
    in_valid = v;
    din      = d;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; din = 3'b000;
    cfg_load = 1'b0; cfg_value = 3'b000; cfg_mask = 3'b000;
    tick();
    n_cmp++; if ({match1, detect1, active1} !== 3'b000) begin n_bad++;
      $display("FAIL reset_u1 got=%b exp=000", {match1, detect1, active1}); end
    n_cmp++; if ({match3, detect3, active3} !== 3'b000) begin n_bad++;
      $display("FAIL reset_u3 got=%b exp=000", {match3, detect3, active3}); end
`ifdef MINTERM_HIT_COUNTER_EN
    n_cmp++; if (hit1 !== 2'd0 || hit3 !== 8'd0) begin n_bad++;
      $display("FAIL reset_hit got=%0d/%0d exp=0/0", hit1, hit3); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    drive(1'b1, 3'b011);
    n_cmp++; if ({match1, detect1, active1} !== 3'b111) begin n_bad++;
      $display("FAIL basic_hit got=%b exp=111", {match1, detect1, active1}); end
    drive(1'b0, 3'b000);
    n_cmp++; if ({match1, detect1, active1} !== 3'b101) begin n_bad++;
      $display("FAIL basic_hold_idle got=%b exp=101", {match1, detect1, active1}); end
    drive(1'b1, 3'b111);
    n_cmp++; if ({match1, detect1, active1} !== 3'b000) begin n_bad++;
      $display("FAIL basic_drop got=%b exp=000", {match1, detect1, active1}); end
  endtask

  task automatic test_exhaustive();
    logic exp_m;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exp_m = (i == 3);
      drive(1'b1, 3'(i));
      n_cmp++; if (match1 !== exp_m || detect1 !== exp_m) begin n_bad++;
        $display("FAIL exhaustive din=%0d got match=%b detect=%b exp=%b", i, match1, detect1, exp_m); end
    end
  endtask

  task automatic test_hold3();
    do_reset();
    drive(1'b1, 3'b011);
    drive(1'b1, 3'b011);
    n_cmp++; if (detect3 !== 1'b0 || active3 !== 1'b0) begin n_bad++;
      $display("FAIL hold3_two got det=%b act=%b exp=0/0", detect3, active3); end
    drive(1'b0, 3'b000);
    n_cmp++; if (detect3 !== 1'b0) begin n_bad++;
      $display("FAIL hold3_gap got=%b exp=0", detect3); end
    drive(1'b1, 3'b011);
    n_cmp++; if (detect3 !== 1'b1 || active3 !== 1'b1) begin n_bad++;
      $display("FAIL hold3_third got det=%b act=%b exp=1/1", detect3, active3); end
    drive(1'b1, 3'b011);
    n_cmp++; if (detect3 !== 1'b0 || active3 !== 1'b1) begin n_bad++;
      $display("FAIL hold3_stay got det=%b act=%b exp=0/1", detect3, active3); end
    drive(1'b1, 3'b000);
    n_cmp++; if (active3 !== 1'b0 || match3 !== 1'b0) begin n_bad++;
      $display("FAIL hold3_drop got act=%b m=%b exp=0/0", active3, match3); end
    drive(1'b1, 3'b011);
    drive(1'b1, 3'b011);
    drive(1'b1, 3'b000);
    n_cmp++; if (detect3 !== 1'b0 || active3 !== 1'b0) begin n_bad++;
      $display("FAIL hold3_broken got det=%b act=%b exp=0/0", detect3, active3); end
    drive(1'b1, 3'b011);
    drive(1'b1, 3'b011);
    n_cmp++; if (detect3 !== 1'b0) begin n_bad++;
      $display("FAIL hold3_restart_early got=%b exp=0", detect3); end
    drive(1'b1, 3'b011);
    n_cmp++; if (detect3 !== 1'b1) begin n_bad++;
      $display("FAIL hold3_restart got=%b exp=1", detect3); end
  endtask

  task automatic test_cfg_load();
    do_reset();
    cfg_load = 1'b1; cfg_value = 3'b100; cfg_mask = 3'b101;
    drive(1'b1, 3'b011);
    cfg_load = 1'b0;
    n_cmp++; if (detect1 !== 1'b0 || match1 !== 1'b0) begin n_bad++;
      $display("FAIL cfg_discard got det=%b m=%b exp=0/0", detect1, match1); end
    drive(1'b1, 3'b110);
    n_cmp++; if ({match1, detect1, active1} !== 3'b111) begin n_bad++;
      $display("FAIL cfg_new_match got=%b exp=111", {match1, detect1, active1}); end
    drive(1'b1, 3'b011);
    n_cmp++; if ({match1, detect1, active1} !== 3'b000) begin n_bad++;
      $display("FAIL cfg_old_pattern got=%b exp=000", {match1, detect1, active1}); end
    drive(1'b1, 3'b100);
    cfg_load = 1'b1;
    drive(1'b0, 3'b000);
    cfg_load = 1'b0;
    n_cmp++; if ({match1, detect1, active1} !== 3'b000) begin n_bad++;
      $display("FAIL cfg_clears_held got=%b exp=000", {match1, detect1, active1}); end
    cfg_load = 1'b1; cfg_value = 3'b111; cfg_mask = 3'b000;
    drive(1'b0, 3'b000);
    cfg_load = 1'b0;
    drive(1'b1, 3'b010);
    n_cmp++; if (detect1 !== 1'b1 || match1 !== 1'b1) begin n_bad++;
      $display("FAIL cfg_mask_zero got det=%b m=%b exp=1/1", detect1, match1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 3'b011);
    drive(1'b1, 3'b011);
    n_cmp++; if (active1 !== 1'b1 || match1 !== 1'b1 || active3 !== 1'b0) begin n_bad++;
      $display("FAIL mid_setup got a1=%b m1=%b a3=%b exp=1/1/0", active1, match1, active3); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({match1, active1, match3, detect3} !== 4'b0000) begin n_bad++;
      $display("FAIL mid_async got=%b exp=0000", {match1, active1, match3, detect3}); end
    #1;
    rst = 1'b0;
    drive(1'b1, 3'b011);
    drive(1'b1, 3'b011);
    n_cmp++; if (detect3 !== 1'b0) begin n_bad++;
      $display("FAIL mid_run_restart got=%b exp=0", detect3); end
    drive(1'b1, 3'b011);
    n_cmp++; if (detect3 !== 1'b1) begin n_bad++;
      $display("FAIL mid_third got=%b exp=1", detect3); end
  endtask

`ifdef MINTERM_HIT_COUNTER_EN
  task automatic test_hit_counter();
    logic [1:0] exp_hit;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      exp_hit = (k >= 2) ? 2'd3 : 2'(k + 1);
      drive(1'b1, 3'b011);
      drive(1'b1, 3'b111);
      n_cmp++; if (hit1 !== exp_hit) begin n_bad++;
        $display("FAIL hit_count event=%0d got=%0d exp=%0d", k + 1, hit1, exp_hit); end
    end
    cfg_load = 1'b1; cfg_value = 3'b011; cfg_mask = 3'b111;
    drive(1'b0, 3'b000);
    cfg_load = 1'b0;
    tick();
    n_cmp++; if (hit1 !== 2'd3) begin n_bad++;
      $display("FAIL hit_after_cfg got=%0d exp=3", hit1); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_exhaustive();
    test_hold3();
    test_cfg_load();
    test_reset_mid();
`ifdef MINTERM_HIT_COUNTER_EN
    test_hit_counter();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
